// File: rtl/fifo_8x16_pkg.sv
// Shared sizing constants for the 16-entry by 8-bit synchronous FIFO.
package fifo_8x16_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int DEPTH       = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int COUNT_WIDTH = 5;
endpackage

// File: rtl/fifo_8x16_mem.sv
// 16x8 register array with a synchronous write port and a registered read port.
module fifo_8x16_mem
  import fifo_8x16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0]            rdata_d, rdata_q;

  // Storage is deliberately left out of reset; only pointers give it meaning.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    always_ff @(posedge clk) begin
      if (we && (waddr == ADDR_WIDTH'(i))) mem_q[i] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_8x16.sv
// Single-clock 16x8 FIFO: pointers, occupancy count, flags and accept qualification.
module fifo_8x16
  import fifo_8x16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [ADDR_WIDTH-1:0]  wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0]  rd_ptr_d, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_d, count_q;
  logic                   wr_acc, rd_acc;

  assign full  = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees the slot in the same cycle;
  // an empty FIFO never bypasses write data to the read side.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_8x16_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_8x16.sv
// Directed self-checking bench for fifo_8x16: fill/drain, wrap, simultaneous access, async reset.
module tb_fifo_8x16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] data_in;
  logic       full, empty;
  logic [7:0] data_out;
  int         n_chk = 0;
  int         n_fail = 0;

  fifo_8x16 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge; return just after the rising edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_state: got e=%b f=%b d=%h want e=1 f=0 d=00", empty, full, data_out);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hFF);
      n_chk++; if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
        n_fail++; $display("FAIL reset_idle%0d: got e=%b f=%b d=%h want e=1 f=0 d=00", i, empty, full, data_out);
      end
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b0, 8'(i));
      n_chk++; if ({full, empty} !== {(i >= 16), 1'b0}) begin
        n_fail++; $display("FAIL fill_flags w%0d: got f=%b e=%b want f=%b e=0", i, full, empty, (i >= 16));
      end
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_drain_underflow();
    logic [7:0] exp_d;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1, 8'h00);
      exp_d = (i <= 16) ? 8'(i) : 8'd16;
      n_chk++; if ({data_out, empty, full} !== {exp_d, (i >= 16), 1'b0}) begin
        n_fail++; $display("FAIL drain r%0d: got d=%h e=%b f=%b want d=%h e=%b f=0", i, data_out, empty, full, exp_d, (i >= 16));
      end
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_chk++; if (data_out !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL wrap_pre r%0d: got %h want %h", i, data_out, 8'h10 + 8'(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'hA0 + 8'(i));
      n_chk++; if (full !== (i == 15)) begin
        n_fail++; $display("FAIL wrap_full w%0d: got %b want %b", i, full, (i == 15));
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_chk++; if ({data_out, empty} !== {8'hA0 + 8'(i), (i == 15)}) begin
        n_fail++; $display("FAIL wrap_read r%0d: got d=%h e=%b want d=%h e=%b", i, data_out, empty, 8'hA0 + 8'(i), (i == 15));
      end
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_simultaneous();
    // Mid-fill: five stored, eight read+write cycles keep occupancy and order.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h31 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'h36 + 8'(i));
      n_chk++; if ({data_out, empty, full} !== {8'h31 + 8'(i), 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL simul_mid c%0d: got d=%h e=%b f=%b want d=%h e=0 f=0", i, data_out, empty, full, 8'h31 + 8'(i));
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_chk++; if ({data_out, empty} !== {8'h39 + 8'(i), (i == 4)}) begin
        n_fail++; $display("FAIL simul_mid_drain r%0d: got d=%h e=%b want d=%h e=%b", i, data_out, empty, 8'h39 + 8'(i), (i == 4));
      end
    end
    // Full: read+write both accepted, new byte lands behind the fifteen survivors.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    step(1'b1, 1'b1, 8'h99);
    n_chk++; if ({data_out, full} !== {8'h40, 1'b1}) begin
      n_fail++; $display("FAIL simul_full: got d=%h f=%b want d=40 f=1", data_out, full);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_chk++; if (data_out !== ((i < 16) ? 8'h40 + 8'(i) : 8'h99)) begin
        n_fail++; $display("FAIL simul_full_drain r%0d: got %h want %h", i, data_out, ((i < 16) ? 8'h40 + 8'(i) : 8'h99));
      end
    end
    n_chk++; if (empty !== 1'b1) begin
      n_fail++; $display("FAIL simul_full_empty: got %b want 1", empty);
    end
    // Empty: write accepted, read dropped, no bypass.
    step(1'b1, 1'b1, 8'h77);
    n_chk++; if ({data_out, empty} !== {8'h99, 1'b0}) begin
      n_fail++; $display("FAIL simul_empty: got d=%h e=%b want d=99 e=0", data_out, empty);
    end
    step(1'b0, 1'b1, 8'h00);
    n_chk++; if ({data_out, empty} !== {8'h77, 1'b1}) begin
      n_fail++; $display("FAIL simul_empty_read: got d=%h e=%b want d=77 e=1", data_out, empty);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    step(1'b0, 1'b1, 8'h00);
    n_chk++; if ({data_out, empty} !== {8'hC0, 1'b0}) begin
      n_fail++; $display("FAIL arst_pre: got d=%h e=%b want d=c0 e=0", data_out, empty);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL arst_immediate: got e=%b f=%b d=%h want e=1 f=0 d=00", empty, full, data_out);
    end
    @(negedge clk); rst = 1'b1;
    step(1'b1, 1'b0, 8'h55);
    n_chk++; if ({empty, data_out} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL arst_post_write: got e=%b d=%h want e=0 d=00", empty, data_out);
    end
    step(1'b0, 1'b1, 8'h00);
    n_chk++; if ({data_out, empty} !== {8'h55, 1'b1}) begin
      n_fail++; $display("FAIL arst_post_read: got d=%h e=%b want d=55 e=1", data_out, empty);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_8x16.md
Name: fifo_8x16

Overview:
Synchronous single-clock FIFO, 16 entries deep, 8 bits wide, with full/empty status flags. It decouples a byte producer from a byte consumer in the same clock domain. Read data is registered. Writes to a full FIFO and reads from an empty FIFO are dropped without corrupting state.

Parameters:
DATA_WIDTH, 8, width of each entry and of data_in/data_out
DEPTH, 16, number of entries; power of two
ADDR_WIDTH, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset (clears state while low)
wr_en  input  1  write request; samples data_in at the rising edge
rd_en  input  1  read request
data_in  input  8  write data
full  output  1  high when 16 entries are stored
empty  output  1  high when 0 entries are stored
data_out  output  8  registered read data

Behaviour:
- Port order is fixed: clk, rst, wr_en, rd_en, data_in, full, empty, data_out. Instances connect positionally.
- Reset: one clock; reset is asynchronous and active-low (rst low clears immediately, independent of clk).
  - On reset: wr_ptr=0, rd_ptr=0, count=0, data_out=8'h00, empty=1, full=0.
  - Memory contents are not cleared.
  - Release is synchronous to the next rising edge.
- State: 4-bit wr_ptr and rd_ptr wrap naturally 15->0. 5-bit count ranges 0..16.
- full = (count==16) and empty = (count==0). Both are combinational from the registered count and valid in the same cycle the count changes.
- Accepted write: wr_en=1 and (full=0 or accepted read in the same cycle).
  - mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Accepted read: rd_en=1 and empty=0.
  - data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
  - Latency: data is visible on data_out one clock after the edge where rd_en is sampled.
- data_out holds its last value when no read is accepted, including reads attempted while empty.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Boundary conditions:
  - Write while full and no read: ignored. Pointers, count and memory are unchanged.
  - Read while empty: ignored. data_out holds; no underflow.
  - Simultaneous read and write while full: both accepted; count stays 16.
  - Simultaneous read and write while empty: write accepted, read ignored (no write-to-read bypass); count becomes 1.
  - Simultaneous read and write, 0<count<16: both accepted; count unchanged; FIFO order preserved.
  - Reset mid-operation: all pointers, count and data_out clear asynchronously. Stored data is discarded logically.
- No X propagation: flags depend only on count, which is always reset.

Decomposition:
- Shared package fifo_8x16_pkg holds the constants DATA_WIDTH=8, DEPTH=16, ADDR_WIDTH=4 and COUNT_WIDTH=5.
- One sub-module, fifo_8x16_mem: 16x8 register array.
  - Synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata, async-low reset of rdata).
- The top level holds pointers, count, flag logic and accept qualification.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> empty=1, full=0, data_out=8'h00; wr_en=rd_en=0 for 3 cycles leaves everything unchanged.
- Fill and overflow: 30 consecutive writes of values 1..30 -> full=1 after the 16th write edge; writes 17..30 ignored; count stays 16.
- Drain and underflow: 30 consecutive reads -> data_out shows 1..16 in order, each one cycle after its read edge. empty=1 after the 16th read. Extra reads leave data_out=16.
- Wrap-around: write 10, read 10, write 16 (values 8'hA0..8'hAF), read 16 -> A0..AF in order; pointers wrap past 15 correctly; full asserts once.
- Simultaneous read/write: with count=5, do 8 cycles of wr_en=rd_en=1 -> count stays 5 and ordering is preserved. With count=16, one both-cycle -> full stays 1 and the new data appears after 15 more reads. With empty, one both-cycle -> empty=0 and data_out unchanged.
- Async reset mid-operation: with 7 entries stored, pull rst low between clock edges -> empty=1 and data_out=0 immediately, without waiting for clk. After release, a write of 8'h55 followed by a read returns 8'h55.
